fp_accum: RTL and testbench



---
 rtl/fp_accum.sv | 217 +++++++++++++++++++++
 tb/tb_fp_accum.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum.sv
// fp_accum: sequential fp32 accumulator for the fp_mult product stream.
// Each accepted operand is summed into the accumulator over a fixed
// ALIGN/ADD/NORM pass. The operand tagged in_last closes the group, and the
// sum and operand count are then presented on the output handshake.
// Rounding truncates toward zero and denormals are flushed to zero.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. A producer holds valid and payload stable until that edge.
// out_valid, once set, is held with stable out_data/out_count until out_ready.
module fp_accum #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;

    state_t           state;
    logic [31:0]      acc_r;
    logic [31:0]      op_r;
    logic             last_r;
    logic [CNT_W-1:0] count_r;

    // ALIGN -> ADD pipeline registers
    logic             spec_r;
    logic [31:0]      spec_val_r;
    logic [26:0]      big_m_r;
    logic [26:0]      small_m_r;
    logic [7:0]       exp_r;
    logic             big_s_r;
    logic             small_s_r;

    // ADD -> NORM pipeline registers
    logic [27:0]      sum_r;
    logic             sum_s_r;

    assign in_ready  = (state == S_IDLE) && !rst;
    assign dbg_state = state;

    // ALIGN datapath: unpack, classify specials, align the smaller operand
    logic        a_s, b_s;
    logic [7:0]  a_e, b_e;
    logic [22:0] a_f, b_f;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        al_spec;
    logic [31:0] al_spec_val;
    logic [26:0] a_m, b_m, al_big_m, al_small_m;
    logic [7:0]  al_exp, al_diff;
    logic        a_big, al_big_s, al_small_s;

    always_comb begin
        a_s = acc_r[31];
        a_e = acc_r[30:23];
        a_f = acc_r[22:0];
        b_s = op_r[31];
        b_e = op_r[30:23];
        b_f = op_r[22:0];
        a_nan = (a_e == 8'hFF) && (a_f != 23'd0);
        b_nan = (b_e == 8'hFF) && (b_f != 23'd0);
        a_inf = (a_e == 8'hFF) && (a_f == 23'd0);
        b_inf = (b_e == 8'hFF) && (b_f == 23'd0);
        al_spec = a_nan || b_nan || a_inf || b_inf;
        if (a_nan || b_nan || (a_inf && b_inf && (a_s != b_s)))
            al_spec_val = QNAN;
        else if (a_inf)
            al_spec_val = {a_s, 8'hFF, 23'd0};
        else
            al_spec_val = {b_s, 8'hFF, 23'd0};
        // exponent 0 means zero (denormals flushed); 3 guard bits below the LSB
        a_m = (a_e == 8'd0) ? 27'd0 : {1'b1, a_f, 3'b000};
        b_m = (b_e == 8'd0) ? 27'd0 : {1'b1, b_f, 3'b000};
        a_big      = (a_e >= b_e);
        al_exp     = a_big ? a_e : b_e;
        al_diff    = a_big ? (a_e - b_e) : (b_e - a_e);
        al_big_m   = a_big ? a_m : b_m;
        al_big_s   = a_big ? a_s : b_s;
        al_small_s = a_big ? b_s : a_s;
        al_small_m = a_big ? b_m : a_m;
        if (al_diff >= 8'd27)
            al_small_m = 27'd0;
        else
            al_small_m = al_small_m >> al_diff;
    end

    // ADD datapath: magnitude add or subtract, larger magnitude sets the sign
    logic [27:0] ad_sum;
    logic        ad_s;

    always_comb begin
        if (big_s_r == small_s_r) begin
            ad_sum = {1'b0, big_m_r} + {1'b0, small_m_r};
            ad_s   = big_s_r;
        end else if (big_m_r >= small_m_r) begin
            ad_sum = {1'b0, big_m_r} - {1'b0, small_m_r};
            ad_s   = big_s_r;
        end else begin
            ad_sum = {1'b0, small_m_r} - {1'b0, big_m_r};
            ad_s   = small_s_r;
        end
    end

    // NORM datapath: leading-one detect, shift so the hidden bit lands on bit 26
    logic [4:0]        lead;
    logic [27:0]       norm_m;
    logic signed [9:0] e_adj;
    logic [31:0]       norm_res;

    always_comb begin
        lead = 5'd0;
        for (int i = 0; i < 28; i++) begin
            if (sum_r[i]) lead = 5'(i);
        end
        if (lead == 5'd27)
            norm_m = sum_r >> 1;
        else
            norm_m = sum_r << (5'd26 - lead);
        e_adj = $signed({2'b00, exp_r}) + $signed({5'b00000, lead}) - 10'sd26;
        if (spec_r)
            norm_res = spec_val_r;
        else if (sum_r == 28'd0)
            norm_res = 32'h00000000;
        else if (e_adj >= 10'sd255)
            norm_res = {sum_s_r, 8'hFF, 23'd0};
        else if (e_adj <= 10'sd0)
            norm_res = {sum_s_r, 31'd0};
        else
            norm_res = {sum_s_r, e_adj[7:0], norm_m[25:3]};
    end

    // Control FSM with all state, accumulator and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc_r      <= 32'd0;
            op_r       <= 32'd0;
            last_r     <= 1'b0;
            count_r    <= '0;
            spec_r     <= 1'b0;
            spec_val_r <= 32'd0;
            big_m_r    <= 27'd0;
            small_m_r  <= 27'd0;
            exp_r      <= 8'd0;
            big_s_r    <= 1'b0;
            small_s_r  <= 1'b0;
            sum_r      <= 28'd0;
            sum_s_r    <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= 32'd0;
            out_count  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_r    <= in_data;
                        last_r  <= in_last;
                        count_r <= (count_r == '1) ? count_r : count_r + CNT_W'(1);
                        state   <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    spec_r     <= al_spec;
                    spec_val_r <= al_spec_val;
                    big_m_r    <= al_big_m;
                    small_m_r  <= al_small_m;
                    exp_r      <= al_exp;
                    big_s_r    <= al_big_s;
                    small_s_r  <= al_small_s;
                    state      <= S_ADD;
                end
                S_ADD: begin
                    sum_r   <= ad_sum;
                    sum_s_r <= ad_s;
                    state   <= S_NORM;
                end
                S_NORM: begin
                    acc_r <= norm_res;
                    if (last_r) begin
                        out_valid <= 1'b1;
                        out_data  <= norm_res;
                        out_count <= count_r;
                        state     <= S_DONE;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        acc_r     <= 32'd0;
                        count_r   <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accum.sv
// Directed testbench for fp_accum with hand-computed fp32 expectations.
module tb_fp_accum;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_count;
    logic [2:0]       dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    fp_accum #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------

    // Present one operand and wait for it to be accepted. Returns #1 after the
    // accept edge. A timeout counts as a failed check.
    task automatic send(input logic [31:0] d, input logic l);
        bit done;
        done     = 1'b0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (in_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout data=%h in_ready never rose", d);
        end
    endtask

    // Called right after the last accept; lat = edges until out_valid seen.
    task automatic collect(output int lat, output logic [31:0] d,
                           output logic [CNT_W-1:0] c);
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) lat = i;
        end
        d = out_data;
        c = out_count;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // ---------------- test tasks ----------------

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b expected 0", in_ready);
        else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b expected 0", out_valid);
        else n_pass++;
        n_checks++;
        if (out_data !== 32'h0) $display("FAIL reset_out_data got %h expected 00000000", out_data);
        else n_pass++;
        n_checks++;
        if (out_count !== '0) $display("FAIL reset_out_count got %0d expected 0", out_count);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready got %b expected 1", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Arithmetic groups, each closed by in_last on its final operand.
    task automatic test_arith();
        logic [31:0]      ops [7][3];
        int               nops [7];
        logic [31:0]      exp_d [7];
        logic [CNT_W-1:0] exp_c [7];
        int               lat;
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        // 1 + 2 + 3 = 6
        ops[0] = '{32'h3F800000, 32'h40000000, 32'h40400000}; nops[0] = 3;
        exp_d[0] = 32'h40C00000; exp_c[0] = 3;
        // 5 + -5 = +0
        ops[1] = '{32'h40A00000, 32'hC0A00000, 32'h0}; nops[1] = 2;
        exp_d[1] = 32'h00000000; exp_c[1] = 2;
        // +Inf + -Inf = NaN
        ops[2] = '{32'h7F800000, 32'hFF800000, 32'h0}; nops[2] = 2;
        exp_d[2] = 32'h7FC00000; exp_c[2] = 2;
        // +Inf + 1 = +Inf
        ops[3] = '{32'h7F800000, 32'h3F800000, 32'h0}; nops[3] = 2;
        exp_d[3] = 32'h7F800000; exp_c[3] = 2;
        // max + max overflows to +Inf
        ops[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0}; nops[4] = 2;
        exp_d[4] = 32'h7F800000; exp_c[4] = 2;
        // 1 + 2^-30: exponent gap 30 >= 27 drops the small operand
        ops[5] = '{32'h3F800000, 32'h30800000, 32'h0}; nops[5] = 2;
        exp_d[5] = 32'h3F800000; exp_c[5] = 2;
        // -1.5 + 0.25 = -1.25; larger magnitude sets the sign
        ops[6] = '{32'hBFC00000, 32'h3E800000, 32'h0}; nops[6] = 2;
        exp_d[6] = 32'hBFA00000; exp_c[6] = 2;
        for (int g = 0; g < 7; g++) begin
            for (int k = 0; k < nops[g]; k++) send(ops[g][k], (k == nops[g] - 1));
            collect(lat, d, c);
            n_checks++;
            if (lat !== 3) $display("FAIL arith_latency[%0d] got %0d expected 3", g, lat);
            else n_pass++;
            n_checks++;
            if (d !== exp_d[g]) $display("FAIL arith_data[%0d] got %h expected %h", g, d, exp_d[g]);
            else n_pass++;
            n_checks++;
            if (c !== exp_c[g]) $display("FAIL arith_count[%0d] got %0d expected %0d", g, c, exp_c[g]);
            else n_pass++;
            release_out();
            n_checks++;
            if (out_valid !== 1'b0) $display("FAIL arith_release[%0d] got out_valid=%b expected 0", g, out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int               lat;
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        int               bad_data;
        int               bad_ready;
        int               bad_valid;
        send(32'h40000000, 1'b1);
        collect(lat, d, c);
        n_checks++;
        if (d !== 32'h40000000) $display("FAIL bp_data got %h expected 40000000", d);
        else n_pass++;
        bad_data = 0;
        bad_ready = 0;
        bad_valid = 0;
        // upstream offers an operand during DONE; it must be ignored
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (out_data !== 32'h40000000) bad_data++;
            if (in_ready !== 1'b0) bad_ready++;
            if (out_valid !== 1'b1) bad_valid++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_checks++;
        if (bad_data != 0) $display("FAIL bp_data_stable got %0d unstable cycles expected 0", bad_data);
        else n_pass++;
        n_checks++;
        if (bad_ready != 0) $display("FAIL bp_in_ready got %0d ready cycles expected 0", bad_ready);
        else n_pass++;
        n_checks++;
        if (bad_valid != 0) $display("FAIL bp_out_valid got %0d low cycles expected 0", bad_valid);
        else n_pass++;
        release_out();
        // next group must start from a cleared accumulator and count
        send(32'h3F800000, 1'b1);
        collect(lat, d, c);
        n_checks++;
        if (d !== 32'h3F800000) $display("FAIL bp_next_data got %h expected 3F800000", d);
        else n_pass++;
        n_checks++;
        if (c !== 1) $display("FAIL bp_next_count got %0d expected 1", c);
        else n_pass++;
        release_out();
    endtask

    task automatic test_back_to_back();
        int               n_ready;
        int               first_i;
        int               last_i;
        int               lat;
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        n_ready = 0;
        first_i = -1;
        last_i  = -1;
        in_valid = 1'b1;
        in_data  = 32'h3F800000;
        in_last  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (in_ready) begin
                n_ready++;
                if (first_i < 0) first_i = i;
                last_i = i;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        n_checks++;
        if (n_ready != 4) $display("FAIL b2b_ready_count got %0d expected 4", n_ready);
        else n_pass++;
        n_checks++;
        if (first_i != 0 || last_i != 12)
            $display("FAIL b2b_ready_spacing got first=%0d last=%0d expected first=0 last=12", first_i, last_i);
        else n_pass++;
        // four 1.0 operands accumulated, a fifth closes the group: 5.0
        send(32'h3F800000, 1'b1);
        collect(lat, d, c);
        n_checks++;
        if (d !== 32'h40A00000) $display("FAIL b2b_data got %h expected 40A00000", d);
        else n_pass++;
        n_checks++;
        if (c !== 5) $display("FAIL b2b_count got %0d expected 5", c);
        else n_pass++;
        release_out();
    endtask

    task automatic test_reset_mid();
        int               lat;
        logic [31:0]      d;
        logic [CNT_W-1:0] c;
        int               early_valid;
        send(32'h40000000, 1'b1);   // now in ALIGN
        @(posedge clk);
        #1;                         // now in ADD
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        early_valid = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid !== 1'b0) early_valid++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (early_valid != 0) $display("FAIL rst_mid_no_output got %0d valid cycles expected 0", early_valid);
        else n_pass++;
        send(32'h3F800000, 1'b1);
        collect(lat, d, c);
        n_checks++;
        if (d !== 32'h3F800000) $display("FAIL rst_mid_data got %h expected 3F800000", d);
        else n_pass++;
        n_checks++;
        if (c !== 1) $display("FAIL rst_mid_count got %0d expected 1", c);
        else n_pass++;
        release_out();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
